mult_pass_sequencer: RTL

Multi-pass schoolbook multiplier for the X25519 datapath. It iterates a limb-by-limb multiply-accumulate pass over operand b, processing PASSES_PER_CYCLE limbs per clock, and returns the full double-width product. It generalises the single multiply pass to configurable limb width, limb count and passes per cycle, and adds its own pass counter, busy/valid handshake and an optional modular fold stage. It sits between the field-arithmetic controller and the register file.

---
 rtl/x25519_pkg.sv | 16 +
 rtl/mult_pass_row.sv | 19 +
 rtl/mult_pass_sequencer.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/x25519_pkg.sv
// Shared types and default sizing for the X25519 multiplier datapath.
package x25519_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FOLD,
        DONE
    } state_t;

    localparam int DEF_LIMB_W     = 8;
    localparam int DEF_NLIMBS     = 33;
    // 2^264 mod (2^255-19) for the default 264-bit operand width.
    localparam int DEF_FOLD_CONST = 9728;

endpackage

// File: rtl/mult_pass_row.sv
// One multiply-accumulate row: the full multiplicand times a single limb,
// placed at its limb position within the double-width product.
module mult_pass_row #(
    parameter int LIMB_W = 8,
    parameter int W      = 264,
    parameter int IDX_W  = 6
) (
    input  logic [W-1:0]      a,
    input  logic [LIMB_W-1:0] limb,
    input  logic [IDX_W-1:0]  idx,
    output logic [2*W-1:0]    prod
);

    logic [W+LIMB_W-1:0] partial;

    assign partial = {{LIMB_W{1'b0}}, a} * {{W{1'b0}}, limb};
    assign prod    = (2*W)'(partial) << (32'(idx) * LIMB_W);

endmodule

// File: rtl/mult_pass_sequencer.sv
// Multi-pass schoolbook multiplier, PASSES_PER_CYCLE limbs of b per clock.
// Define MULT_SEQ_FOLD_EN to add a fold stage reducing the product modulo 2^255-19.
module mult_pass_sequencer
    import x25519_pkg::*;
#(
    parameter int  LIMB_W           = DEF_LIMB_W,
    parameter int  NLIMBS           = DEF_NLIMBS,
    parameter int  PASSES_PER_CYCLE = 1,
    parameter int  FOLD_CONST       = DEF_FOLD_CONST,
    localparam int W                = LIMB_W * NLIMBS,
    localparam int IDX_W            = (NLIMBS > 1) ? $clog2(NLIMBS) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [W-1:0]     a,
    input  logic [W-1:0]     b,
    output logic             busy,
    output logic [IDX_W-1:0] pass_idx,
    output logic             out_valid,
    output logic [2*W-1:0]   out
);

    localparam int LAST_IDX = NLIMBS - PASSES_PER_CYCLE;

    generate
        if (PASSES_PER_CYCLE < 1 || (NLIMBS % PASSES_PER_CYCLE) != 0) begin : g_bad_ppc
            $error("PASSES_PER_CYCLE must be a positive divisor of NLIMBS");
        end
        if (FOLD_CONST < 0) begin : g_bad_fold
            $error("FOLD_CONST must be non-negative");
        end
    endgenerate

    state_t             state_reg, state_next;
    logic [W-1:0]       a_reg, b_reg;
    logic [2*W-1:0]     acc_reg, out_reg;
    logic [IDX_W-1:0]   pass_idx_reg;
    logic [2*W-1:0]     row_prod [PASSES_PER_CYCLE];
    logic [2*W-1:0]     row_sum, acc_sum;
    logic               last_group;

    genvar gi;
    generate
        for (gi = 0; gi < PASSES_PER_CYCLE; gi++) begin : g_row
            logic [IDX_W-1:0] limb_idx;
            assign limb_idx = pass_idx_reg + IDX_W'(gi);
            mult_pass_row #(
                .LIMB_W (LIMB_W),
                .W      (W),
                .IDX_W  (IDX_W)
            ) u_row (
                .a    (a_reg),
                .limb (b_reg[32'(limb_idx) * LIMB_W +: LIMB_W]),
                .idx  (limb_idx),
                .prod (row_prod[gi])
            );
        end
    endgenerate

    always_comb begin
        row_sum = '0;
        for (int k = 0; k < PASSES_PER_CYCLE; k++) begin
            row_sum = row_sum + row_prod[k];
        end
    end

    assign acc_sum    = acc_reg + row_sum;
    assign last_group = (pass_idx_reg == IDX_W'(LAST_IDX));

`ifdef MULT_SEQ_FOLD_EN
    logic [2*W-1:0] fold_val;
    // High half is worth FOLD_CONST per unit, since 2^W == FOLD_CONST mod p.
    assign fold_val = (2*W)'(acc_reg[W-1:0])
                    + (2*W)'(acc_reg[2*W-1:W]) * (2*W)'(FOLD_CONST);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        busy       = (state_reg != IDLE);
        out_valid  = (state_reg == DONE);
        case (state_reg)
            IDLE: if (en) state_next = RUN;
            RUN: begin
                if (last_group) begin
`ifdef MULT_SEQ_FOLD_EN
                    state_next = FOLD;
`else
                    state_next = DONE;
`endif
                end
            end
            FOLD:    state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_reg        <= '0;
            b_reg        <= '0;
            acc_reg      <= '0;
            out_reg      <= '0;
            pass_idx_reg <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (en) begin
                        a_reg        <= a;
                        b_reg        <= b;
                        acc_reg      <= '0;
                        pass_idx_reg <= '0;
                    end
                end
                RUN: begin
                    acc_reg <= acc_sum;
                    if (last_group) begin
                        pass_idx_reg <= '0;
`ifndef MULT_SEQ_FOLD_EN
                        out_reg      <= acc_sum;
`endif
                    end else begin
                        pass_idx_reg <= pass_idx_reg + IDX_W'(PASSES_PER_CYCLE);
                    end
                end
`ifdef MULT_SEQ_FOLD_EN
                FOLD: out_reg <= fold_val;
`endif
                default: ;
            endcase
        end
    end

    assign pass_idx = pass_idx_reg;
    assign out      = out_reg;

endmodule
